// File: rtl/uart_tx_queue.sv
// Transmit byte queue ahead of the UART transmitter: a circular FIFO plus a launch FSM that
// holds tx_start across at least one baud tick, then waits for the frame to complete.
module uart_tx_queue #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          ticks_per_bit,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 tx_done,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data_in,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG2:0]  count,
    output logic                 overflow,
    output logic                 busy
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthCount = Depth[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] CountOne = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne = (DEPTH_LOG2)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             hold_cnt_q, hold_cnt_d;
    logic                    tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0]    tx_data_q, tx_data_d;
    logic [DATA_BITS-1:0]    mem_q [Depth];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    tx_done_q;

    logic        pop;
    logic        push;
    logic        done_rise;
    logic [31:0] hold_target;

    assign hold_target = (ticks_per_bit == 32'd0) ? 32'd1 : ticks_per_bit;
    assign done_rise   = tx_done & ~tx_done_q;
    assign pop         = (state_q == StIdle) && (count_q != '0);
    // A full queue still takes a word when the launcher frees a slot in the same cycle.
    assign push        = wr_en && ((count_q != DepthCount) || pop);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d    = StStart;
                    hold_cnt_d = '0;
                end
            end
            StStart: begin
                if (hold_cnt_q == hold_target) begin
                    state_d = StWait;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            StWait: begin
                // Edges seen while still in StStart are deliberately forgotten.
                if (done_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs, registered so tx_start/tx_data_in come straight from flops
    always_comb begin
        tx_start_d = (state_d == StStart);
        tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    end

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        overflow_d = overflow_q | (wr_en & ~push);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_done_q  <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_done_q  <= tx_done;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data_in = tx_data_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign full       = (count_q == DepthCount);
    assign empty      = (count_q == '0);
    assign busy       = (state_q != StIdle);

endmodule
